// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL responder over a flop-based word RAM. Latency one cycle.
// The single response buffer holds d_* until it fires, and a_ready drops while a response is stalled.
module tl_ul_ram_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          SOURCE_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [31:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic                d_corrupt
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    logic [31:0] mem [DEPTH_WORDS];

    logic             a_fire;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             is_put;
    logic             is_get;
    logic             misaligned;
    logic             in_range;
    logic             denied;
    logic             wr_en;
    logic [2:0]       rsp_opcode;
    logic [31:0]      rsp_data;
    logic             rsp_corrupt;
    logic             unused_inputs;

    // d_ready feeds a_ready directly so a draining response never costs a bubble.
    assign a_ready = !reset && (!d_valid || d_ready);
    assign a_fire  = a_valid && a_ready;

    assign offset   = a_address - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign in_range = {1'b0, offset} < SPAN;

    always_comb begin
        is_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
        is_get     = (a_opcode == OP_GET);
        misaligned = 1'b0;
        case (a_size)
            2'd1:    misaligned = a_address[0];
            2'd2:    misaligned = |a_address[1:0];
            default: misaligned = 1'b0;
        endcase
        denied = !(is_put || is_get) || (a_size == 2'd3) || misaligned || !in_range;
    end

    // Poisoned write data is acknowledged normally but never reaches the array.
    assign wr_en = a_fire && is_put && !denied && !a_corrupt;

    always_comb begin
        rsp_opcode  = is_put ? OP_ACK : OP_ACK_DATA;
        rsp_data    = 32'd0;
        rsp_corrupt = denied && !is_put;
        if (is_get && !denied) begin
            rsp_data = mem[idx];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem[idx][b*8 +: 8] <= a_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 2'd0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= 32'd0;
            d_corrupt <= 1'b0;
        end else if (a_fire) begin
            d_valid   <= 1'b1;
            d_opcode  <= rsp_opcode;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= denied;
            d_data    <= rsp_data;
            d_corrupt <= rsp_corrupt;
        end else if (d_ready) begin
            d_valid   <= 1'b0;
        end
    end

    assign d_param = 2'd0;
    assign d_sink  = 1'b0;

    assign unused_inputs = ^{a_param, offset};

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed bench for tl_ul_ram_responder: each task drives one scenario and checks inline.
module tb_tl_ul_ram_responder;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [2:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [2:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    int errors = 0;
    int checks = 0;

    tl_ul_ram_responder #(
        .DEPTH_WORDS(64),
        .BASE_ADDR  (32'h8000_0000),
        .SOURCE_W   (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_param  (a_param),
        .a_size   (a_size),
        .a_source (a_source),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .a_corrupt(a_corrupt),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_param  (d_param),
        .d_size   (d_size),
        .d_source (d_source),
        .d_sink   (d_sink),
        .d_denied (d_denied),
        .d_data   (d_data),
        .d_corrupt(d_corrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_req(input logic [2:0] op, input logic [1:0] sz, input logic [2:0] src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic cor);
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = cor;
    endtask

    // Presents one request, waits (bounded) for acceptance, returns at accept edge + 1.
    task automatic issue(input logic [2:0] op, input logic [1:0] sz, input logic [2:0] src,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic cor);
        bit ok;
        ok = 1'b0;
        set_req(op, sz, src, addr, mask, data, cor);
        a_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: a_ready=%0b required 1 within 50 cycles", a_ready);
        end
        @(posedge clock);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic drain();
        d_ready = 1'b1;
        a_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready_forced: got %0b want 0", a_ready); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid: got %0b want 0", d_valid); end
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready_idle: got %0b want 1", a_ready); end
        checks++; if ({d_opcode, d_size, d_source, d_denied, d_corrupt} !== 11'd0) begin
            errors++; $display("FAIL rst_d_fields: got %h want 0", {d_opcode, d_size, d_source, d_denied, d_corrupt});
        end
        checks++; if (d_data !== 32'd0) begin errors++; $display("FAIL rst_d_data: got %h want 0", d_data); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_put_get();
        issue(3'd0, 2'd2, 3'd2, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL put_d_valid: got %0b want 1", d_valid); end
        checks++; if (d_opcode !== 3'd0) begin errors++; $display("FAIL put_opcode: got %0d want 0", d_opcode); end
        checks++; if (d_source !== 3'd2) begin errors++; $display("FAIL put_source: got %0d want 2", d_source); end
        checks++; if (d_denied !== 1'b0) begin errors++; $display("FAIL put_denied: got %0b want 0", d_denied); end
        checks++; if (d_size !== 2'd2) begin errors++; $display("FAIL put_size: got %0d want 2", d_size); end
        checks++; if ({d_param, d_sink} !== 3'd0) begin errors++; $display("FAIL put_param_sink: got %0d want 0", {d_param, d_sink}); end
        issue(3'd4, 2'd2, 3'd5, 32'h8000_0010, 4'h0, 32'h0, 1'b0);
        checks++; if (d_opcode !== 3'd1) begin errors++; $display("FAIL get_opcode: got %0d want 1", d_opcode); end
        checks++; if (d_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL get_data: got %h want deadbeef", d_data); end
        checks++; if (d_source !== 3'd5) begin errors++; $display("FAIL get_source: got %0d want 5", d_source); end
        checks++; if (d_corrupt !== 1'b0) begin errors++; $display("FAIL get_corrupt: got %0b want 0", d_corrupt); end
    endtask

    task automatic test_partial();
        issue(3'd1, 2'd2, 3'd3, 32'h8000_0010, 4'b0101, 32'h1122_3344, 1'b0);
        checks++; if (d_opcode !== 3'd0 || d_denied !== 1'b0) begin
            errors++; $display("FAIL partial_ack: got op %0d den %0b want op 0 den 0", d_opcode, d_denied);
        end
        issue(3'd4, 2'd2, 3'd1, 32'h8000_0010, 4'h1, 32'h0, 1'b0);
        checks++; if (d_data !== 32'hDE22_BE44) begin errors++; $display("FAIL partial_data: got %h want de22be44", d_data); end
    endtask

    task automatic test_corrupt_put();
        issue(3'd0, 2'd2, 3'd4, 32'h8000_0010, 4'hF, 32'h0000_0000, 1'b1);
        checks++; if (d_opcode !== 3'd0 || d_denied !== 1'b0 || d_corrupt !== 1'b0) begin
            errors++; $display("FAIL poison_ack: got op %0d den %0b cor %0b want 0 0 0", d_opcode, d_denied, d_corrupt);
        end
        issue(3'd4, 2'd2, 3'd4, 32'h8000_0010, 4'hF, 32'h0, 1'b0);
        checks++; if (d_data !== 32'hDE22_BE44) begin errors++; $display("FAIL poison_dropped: got %h want de22be44", d_data); end
    endtask

    task automatic test_denials();
        issue(3'd4, 2'd2, 3'd1, 32'h8000_0100, 4'hF, 32'h0, 1'b0);
        checks++; if ({d_opcode, d_denied, d_corrupt} !== {3'd1, 1'b1, 1'b1} || d_data !== 32'd0) begin
            errors++; $display("FAIL deny_range: got op %0d den %0b cor %0b data %h want 1 1 1 0", d_opcode, d_denied, d_corrupt, d_data);
        end
        issue(3'd4, 2'd2, 3'd2, 32'h8000_0002, 4'hF, 32'h0, 1'b0);
        checks++; if (d_denied !== 1'b1 || d_data !== 32'd0) begin
            errors++; $display("FAIL deny_misalign: got den %0b data %h want 1 0", d_denied, d_data);
        end
        issue(3'd6, 2'd2, 3'd3, 32'h8000_0000, 4'hF, 32'h0, 1'b0);
        checks++; if ({d_opcode, d_denied, d_corrupt} !== {3'd1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL deny_opcode: got op %0d den %0b cor %0b want 1 1 1", d_opcode, d_denied, d_corrupt);
        end
        issue(3'd4, 2'd3, 3'd4, 32'h8000_0000, 4'hF, 32'h0, 1'b0);
        checks++; if (d_denied !== 1'b1 || d_size !== 2'd3) begin
            errors++; $display("FAIL deny_size3: got den %0b size %0d want 1 3", d_denied, d_size);
        end
        // Below the base the subtraction wraps to a huge offset.
        issue(3'd0, 2'd2, 3'd5, 32'h7FFF_FFFC, 4'hF, 32'h1234_5678, 1'b0);
        checks++; if ({d_opcode, d_denied, d_corrupt} !== {3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL deny_put_low: got op %0d den %0b cor %0b want 0 1 0", d_opcode, d_denied, d_corrupt);
        end
        issue(3'd0, 2'd2, 3'd6, 32'h8000_00FC, 4'hF, 32'hCAFE_F00D, 1'b0);
        checks++; if (d_denied !== 1'b0) begin errors++; $display("FAIL last_word_put: got den %0b want 0", d_denied); end
        issue(3'd4, 2'd1, 3'd7, 32'h8000_00FE, 4'hF, 32'h0, 1'b0);
        checks++; if (d_denied !== 1'b0 || d_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL last_word_get: got den %0b data %h want 0 cafef00d", d_denied, d_data);
        end
    endtask

    task automatic test_backpressure();
        drain();
        d_ready = 1'b0;
        issue(3'd4, 2'd2, 3'd1, 32'h8000_0010, 4'hF, 32'h0, 1'b0);
        set_req(3'd4, 2'd2, 3'd6, 32'h8000_00FC, 4'hF, 32'h0, 1'b0);
        a_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready: got %0b want 0", a_ready); end
            checks++; if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 3'd1, 32'hDE22_BE44}) begin
                errors++; $display("FAIL bp_hold: got v%0b op%0d src%0d %h want v1 op1 src1 de22be44", d_valid, d_opcode, d_source, d_data);
            end
        end
        @(posedge clock);
        #1 d_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b want 1", a_ready); end
        @(posedge clock);
        #1 a_valid = 1'b0;
        checks++; if ({d_valid, d_source, d_data} !== {1'b1, 3'd6, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL bp_next: got v%0b src%0d %h want v1 src6 cafef00d", d_valid, d_source, d_data);
        end
        @(posedge clock);
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", d_valid); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            issue(3'd0, 2'd2, 3'(k), 32'h8000_0000 + 32'(k * 4), 4'hF, 32'h1000_0000 + 32'(k), 1'b0);
        end
        drain();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                checks++; if ({d_valid, d_source, d_data} !== {1'b1, 3'(k - 1), 32'h1000_0000 + 32'(k - 1)}) begin
                    errors++; $display("FAIL stream_rsp%0d: got v%0b src%0d %h want v1 src%0d %h", k - 1,
                                       d_valid, d_source, d_data, (k - 1) % 8, 32'h1000_0000 + 32'(k - 1));
                end
            end
            if (k < 16) begin
                set_req(3'd4, 2'd2, 3'(k), 32'h8000_0000 + 32'(k * 4), 4'hF, 32'h0, 1'b0);
                a_valid = 1'b1;
                @(negedge clock);
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %0b want 1", k, a_ready); end
            end else begin
                a_valid = 1'b0;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_random_ready();
        logic [34:0] exp_q[$];
        logic [34:0] exp;
        int sent;
        int recv;
        bit af;
        bit df;
        sent = 0;
        recv = 0;
        drain();
        set_req(3'd4, 2'd2, 3'd0, 32'h8000_0000, 4'hF, 32'h0, 1'b0);
        a_valid = 1'b1;
        d_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
            @(negedge clock);
            af = a_valid && a_ready;
            df = d_valid && d_ready;
            if (df) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious: got src%0d %h want no response", d_source, d_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({d_source, d_data} !== exp) begin
                        errors++; $display("FAIL rnd_rsp%0d: got %h want %h", recv, {d_source, d_data}, exp);
                    end
                end
                recv++;
            end
            if (af) begin
                exp_q.push_back({3'(sent), 32'h1000_0000 + 32'(sent % 16)});
                sent++;
            end
            @(posedge clock);
            #1;
            d_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                set_req(3'd4, 2'd2, 3'(sent), 32'h8000_0000 + 32'((sent % 16) * 4), 4'hF, 32'h0, 1'b0);
                a_valid = 1'b1;
            end else begin
                a_valid = 1'b0;
            end
        end
        checks++; if (recv != 20 || exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_count: got %0d responses %0d pending want 20 0", recv, exp_q.size());
        end
        drain();
        drain();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rnd_dup: got d_valid %0b want 0", d_valid); end
    endtask

    task automatic test_async_reset();
        drain();
        issue(3'd0, 2'd2, 3'd2, 32'h8000_0080, 4'hF, 32'hA5A5_5A5A, 1'b0);
        drain();
        d_ready = 1'b0;
        issue(3'd4, 2'd2, 3'd7, 32'h8000_0080, 4'hF, 32'h0, 1'b0);
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL arst_pending: got %0b want 1", d_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (d_valid !== 1'b0 || a_ready !== 1'b0) begin
            errors++; $display("FAIL arst_clear: got v%0b rdy%0b want v0 rdy0", d_valid, a_ready);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        d_ready = 1'b1;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL arst_lost: got %0b want 0", d_valid); end
        issue(3'd4, 2'd2, 3'd3, 32'h8000_0080, 4'hF, 32'h0, 1'b0);
        checks++; if ({d_opcode, d_source, d_data} !== {3'd1, 3'd3, 32'hA5A5_5A5A}) begin
            errors++; $display("FAIL arst_retain: got op%0d src%0d %h want op1 src3 a5a55a5a", d_opcode, d_source, d_data);
        end
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_param = 3'd0;
        d_ready = 1'b1;
        set_req(3'd0, 2'd0, 3'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        test_reset();
        test_put_get();
        test_partial();
        test_corrupt_put();
        test_denials();
        test_backpressure();
        test_back_to_back();
        test_random_ready();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
